input_port_unit: RTL and testbench



---
 rtl/noc_pkg.sv | 26 ++
 rtl/noc_sync_fifo.sv | 59 +++++
 rtl/input_port_unit.sv | 98 +++++++++
 tb/tb_input_port_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field positions, route label encodings and
// mesh coordinate width used by the router input stage.
package noc_pkg;

  // Flit field positions within a 40-bit flit
  localparam int SRC_MSB  = 39;
  localparam int SRC_LSB  = 36;
  localparam int DST_MSB  = 35;
  localparam int DST_LSB  = 32;
  localparam int TS_MSB   = 31;
  localparam int TS_LSB   = 24;
  localparam int TYPE_MSB = 1;
  localparam int TYPE_LSB = 0;

  // Mesh coordinates are 0..3 on each axis
  localparam int COORD_W = 2;

  // One-hot output direction labels; all-ones means no valid head flit
  localparam logic [3:0] LBL_W     = 4'b1000;
  localparam logic [3:0] LBL_N     = 4'b0100;
  localparam logic [3:0] LBL_E     = 4'b0010;
  localparam logic [3:0] LBL_S     = 4'b0001;
  localparam logic [3:0] LBL_LOCAL = 4'b0000;
  localparam logic [3:0] LBL_NONE  = 4'b1111;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous show-ahead FIFO. The head entry is visible on rdata as soon
// as the FIFO is non-empty; rdata reads zero when empty. Storage is not
// reset, only pointers and count, so a reset flushes all contents.
module noc_sync_fifo #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [DATASIZE-1:0] wdata,
  output logic [DATASIZE-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic [WIDTH:0]      count
);

  localparam logic [WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [WIDTH:0]   CNT_ONE  = 1;
  localparam logic [WIDTH:0]   CNT_FULL = DEPTH[WIDTH:0];

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH-1:0]    rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Status is taken from the registered count only, so no input reaches full
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Flit storage write; data path carries no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: buffers flits, computes the XY route label of the head
// flit and presents it to the switch allocator. Optional statistics
// (flit_cnt, max_occ) are built when INPORT_STATS_EN is defined.
module input_port_unit
  import noc_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40,
  parameter int X_COORD  = 0,
  parameter int Y_COORD  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATASIZE-1:0] in_data,
  output logic                full,
  input  logic                out_ready,
  output logic [3:0]          label,
  output logic [DATASIZE-1:0] data_out,
  output logic [WIDTH:0]      occupancy
`ifdef INPORT_STATS_EN
  ,
  output logic [15:0]         flit_cnt,
  output logic [WIDTH:0]      max_occ
`endif
);

  localparam logic [COORD_W-1:0] X_C = X_COORD[COORD_W-1:0];
  localparam logic [COORD_W-1:0] Y_C = Y_COORD[COORD_W-1:0];

  logic                      empty;
  logic                      push;
  logic                      pop;
  logic [DST_MSB-DST_LSB:0]  dst;
  logic [COORD_W-1:0]        dx;
  logic [COORD_W-1:0]        dy;

  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;

  noc_sync_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .DATASIZE (DATASIZE)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (data_out),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign dst = data_out[DST_MSB:DST_LSB];
  assign dx  = dst[2*COORD_W-1:COORD_W];
  assign dy  = dst[COORD_W-1:0];

  // XY routing: resolve the X axis completely before looking at Y
  always_comb begin
    label = LBL_LOCAL;
    if (empty)          label = LBL_NONE;
    else if (dx < X_C)  label = LBL_W;
    else if (dx > X_C)  label = LBL_E;
    else if (dy < Y_C)  label = LBL_N;
    else if (dy > Y_C)  label = LBL_S;
  end

`ifdef INPORT_STATS_EN
  localparam logic [WIDTH:0] CNT_ONE = 1;
  logic [WIDTH:0] occ_nxt;

  // Next-cycle count so the high-water mark tracks occupancy without lag
  always_comb begin
    occ_nxt = occupancy;
    case ({push, pop})
      2'b10:   occ_nxt = occupancy + CNT_ONE;
      2'b01:   occ_nxt = occupancy - CNT_ONE;
      default: occ_nxt = occupancy;
    endcase
  end

  // Popped-flit counter (saturating) and occupancy high-water mark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt <= '0;
      max_occ  <= '0;
    end else begin
      if (pop && flit_cnt != 16'hFFFF) flit_cnt <= flit_cnt + 16'd1;
      if (occ_nxt > max_occ)           max_occ  <= occ_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_input_port_unit.sv
// Bench for input_port_unit at router coordinate (1,1): table-driven route
// decode, directed corner sequences and randomized traffic checked against
// a queue-based reference model.
module tb_input_port_unit;

  localparam int DEPTH = 8;
  localparam int WIDTH = 3;
  localparam int DS    = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DS-1:0] in_data;
  logic          full;
  logic          out_ready;
  logic [3:0]    label;
  logic [DS-1:0] data_out;
  logic [WIDTH:0] occupancy;
`ifdef INPORT_STATS_EN
  logic [15:0]    flit_cnt;
  logic [WIDTH:0] max_occ;
`endif

  input_port_unit #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DS), .X_COORD(1), .Y_COORD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .full(full), .out_ready(out_ready), .label(label), .data_out(data_out),
    .occupancy(occupancy)
`ifdef INPORT_STATS_EN
    , .flit_cnt(flit_cnt), .max_occ(max_occ)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DS-1:0] q[$];
  int            m_fcnt;
  int            m_hw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // XY routing rule for router (1,1), from the destination coordinates
  function automatic logic [3:0] ref_label(input bit is_empty, input logic [DS-1:0] f);
    int dx, dy;
    if (is_empty) return 4'b1111;
    dx = int'(f[35:34]);
    dy = int'(f[33:32]);
    if (dx < 1) return 4'b1000;
    if (dx > 1) return 4'b0010;
    if (dy < 1) return 4'b0100;
    if (dy > 1) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".data"}, 64'(data_out), (q.size() == 0) ? 64'd0 : 64'(q[0]));
    chk({tag, ".label"}, 64'(label), 64'(ref_label(q.size() == 0, (q.size() == 0) ? '0 : q[0])));
    chk({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
    chk({tag, ".occ"}, 64'(occupancy), 64'(q.size()));
  endtask

  // One clock: drive, take the edge, update the model, compare at edge+1
  task automatic cycle(input bit iv, input logic [DS-1:0] d, input bit rdy, input string tag);
    bit m_push, m_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    m_push = iv && (q.size() < DEPTH);
    m_pop  = rdy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (m_pop) begin
      void'(q.pop_front());
      if (m_fcnt < 65535) m_fcnt++;
    end
    if (m_push) q.push_back(d);
    if (q.size() > m_hw) m_hw = q.size();
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_fcnt = 0;
    m_hw   = 0;
    chk("rst.label", 64'(label), 64'hF);
    chk("rst.data", 64'(data_out), 64'd0);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.occ", 64'(occupancy), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DS-1:0] mk_flit(input logic [3:0] dst, input logic [7:0] tag);
    return {4'h3, dst, tag, 14'h2A5, tag, 2'b10};
  endfunction

  typedef struct {
    logic [3:0] dst;
    logic [3:0] exp_label;
  } route_vec_t;

  route_vec_t rv[5];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    m_fcnt = 0; m_hw = 0;
    #12;
    chk("init.label", 64'(label), 64'hF);
    chk("init.data", 64'(data_out), 64'd0);
    chk("init.full", 64'(full), 64'd0);
    chk("init.occ", 64'(occupancy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Route decode table at (1,1)
    rv[0] = '{4'b0001, 4'b1000};
    rv[1] = '{4'b1001, 4'b0010};
    rv[2] = '{4'b0100, 4'b0100};
    rv[3] = '{4'b0110, 4'b0001};
    rv[4] = '{4'b0101, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, mk_flit(rv[i].dst, 8'(i)), 1'b0, "route.push");
      chk("route.tbl", 64'(label), 64'(rv[i].exp_label));
      cycle(1'b0, '0, 1'b1, "route.pop");
      chk("route.empty", 64'(label), 64'hF);
    end

    // Fill to full, hold a ninth flit, free one slot, then drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk_flit(4'(i), 8'(8'h10 + i)), 1'b0, "fill");
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.occ", 64'(occupancy), 64'd8);
    cycle(1'b1, 40'hA5, 1'b0, "hold");
    chk("hold.occ", 64'(occupancy), 64'd8);
    cycle(1'b1, 40'hA5, 1'b1, "popfull");
    chk("popfull.full", 64'(full), 64'd0);
    chk("popfull.occ", 64'(occupancy), 64'd7);
    cycle(1'b1, 40'hA5, 1'b0, "late");
    chk("late.occ", 64'(occupancy), 64'd8);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, "drain");
    chk("drain.last", 64'(data_out), 64'hA5);
    cycle(1'b0, '0, 1'b1, "drain");
    chk("drain.empty", 64'(occupancy), 64'd0);

    // Steady push+pop at occupancy 4 across several pointer wraps
    for (int i = 0; i < 4; i++) cycle(1'b1, mk_flit(4'(i * 3), 8'(8'h40 + i)), 1'b0, "pre4");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, mk_flit(4'(i), 8'(8'h80 + i)), 1'b1, "pp");
      chk("pp.occ", 64'(occupancy), 64'd4);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, "post4");

    // out_ready on an empty FIFO must be ignored
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "rdyempty");
    chk("rdyempty.label", 64'(label), 64'hF);
    cycle(1'b1, mk_flit(4'b1010, 8'hEE), 1'b0, "afterempty");
    chk("afterempty.data", 64'(data_out), 64'(mk_flit(4'b1010, 8'hEE)));
    cycle(1'b0, '0, 1'b1, "afterempty.pop");

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      logic [DS-1:0] d;
      d = {8'($urandom), 32'($urandom)};
      cycle(1'($urandom_range(0, 99) < 60), d, 1'($urandom_range(0, 99) < 50), "rand");
    end

    // Reset mid-stream at occupancy 5
    for (int i = 0; i < 5 && q.size() < 5; i++) ;
    while (q.size() > 0) cycle(1'b0, '0, 1'b1, "predrain");
    for (int i = 0; i < 5; i++) cycle(1'b1, mk_flit(4'(i), 8'(8'hC0 + i)), 1'b0, "pre5");
    chk("pre5.occ", 64'(occupancy), 64'd5);
    mid_reset();
    check_model("postrst");
    cycle(1'b1, 40'h12_3456_789A, 1'b0, "postrst.push");
    chk("postrst.head", 64'(data_out), 64'h12_3456_789A);
    cycle(1'b0, '0, 1'b1, "postrst.pop");
    cycle(1'b0, '0, 1'b1, "postrst.extra");
    chk("postrst.only", 64'(occupancy), 64'd0);

`ifdef INPORT_STATS_EN
    // 20 flits through with a peak occupancy of 6
    mid_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, mk_flit(4'(i), 8'(i)), 1'b0, "st.fill");
    for (int i = 0; i < 14; i++) cycle(1'b1, mk_flit(4'(i), 8'(i)), 1'b1, "st.pp");
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, "st.drain");
    chk("stats.flit_cnt", 64'(flit_cnt), 64'd20);
    chk("stats.max_occ", 64'(max_occ), 64'd6);
    chk("stats.model_cnt", 64'(flit_cnt), 64'(m_fcnt));
    chk("stats.model_hw", 64'(max_occ), 64'(m_hw));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
